mem_arbiter: RTL

//  Shares the single memory port between the instruction fetch unit (loads only) and the

---
 rtl/mem_arbiter_pkg.sv | 42 ++++
 rtl/mem_tag_table.sv | 43 ++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: memory interface types, tag owners
// and arbiter states.
package mem_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int MEM_TAG_W        = 4;
  localparam int NUM_MEM_TAGS     = 1 << MEM_TAG_W;
  localparam int MEM_BLOCK_W      = 64;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 3;

  typedef logic [ADDR_W-1:0]      ADDR;
  typedef logic [MEM_TAG_W-1:0]   MEM_TAG;
  typedef logic [MEM_BLOCK_W-1:0] MEM_BLOCK;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DC   = 2'd2
  } MEM_OWNER;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_DC = 2'd2
  } MEM_ARB_STATE;

  // dcache has priority unless fetch has waited through the starvation limit
  function automatic MEM_ARB_STATE arb_pick(input logic if_req, input logic dc_req,
                                            input logic if_starved);
    if (dc_req && !if_starved) return ARB_GNT_DC;
    if (if_req) return ARB_GNT_IF;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Ownership table for outstanding memory load tags: allocate on accept,
// retire on data return, bulk-squash of fetch-owned entries.
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     alloc_en_i,
  input  MEM_TAG   alloc_tag_i,
  input  MEM_OWNER alloc_owner_i,
  input  logic     squash_if_i,
  input  MEM_TAG   ret_tag_i,
  output MEM_OWNER ret_owner_o,
  output logic     ret_squashed_o
);

  MEM_OWNER                owner_q [NUM_MEM_TAGS];
  logic [NUM_MEM_TAGS-1:0] squashed_q;

  // Retire is applied before allocate so a tag reused in its return cycle keeps the new owner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) owner_q[i] <= OWN_NONE;
      squashed_q <= '0;
    end else begin
      for (int i = 1; i < NUM_MEM_TAGS; i++) begin
        if (squash_if_i && owner_q[i] == OWN_IF) squashed_q[i] <= 1'b1;
        if (ret_tag_i == MEM_TAG'(i)) begin
          owner_q[i]    <= OWN_NONE;
          squashed_q[i] <= 1'b0;
        end
        if (alloc_en_i && alloc_tag_i == MEM_TAG'(i)) begin
          owner_q[i]    <= alloc_owner_i;
          squashed_q[i] <= squash_if_i && (alloc_owner_i == OWN_IF);
        end
      end
    end
  end

  assign ret_owner_o    = owner_q[ret_tag_i];
  assign ret_squashed_o = squashed_q[ret_tag_i];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the data cache and
// routes returning load data back to the owner of each tag.
//   state      | meaning
//   ARB_IDLE   | no grant, memory sees MEM_NONE
//   ARB_GNT_IF | fetch owns the port until accepted or its request drops
//   ARB_GNT_DC | dcache owns the port until accepted or its request drops
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       if_req_i,
  input  ADDR        if_addr_i,
  input  logic       if_squash_i,
  output logic       if_ack_o,
  output MEM_TAG     if_tag_o,
  output MEM_TAG     if_data_tag_o,
  output MEM_BLOCK   if_data_o,
  input  logic       dc_req_i,
  input  MEM_COMMAND dc_cmd_i,
  input  ADDR        dc_addr_i,
  input  MEM_BLOCK   dc_wdata_i,
  output logic       dc_ack_o,
  output MEM_TAG     dc_tag_o,
  output MEM_TAG     dc_data_tag_o,
  output MEM_BLOCK   dc_data_o,
  output MEM_COMMAND mem_command_o,
  output ADDR        mem_addr_o,
  output MEM_BLOCK   mem_wdata_o,
  input  MEM_TAG     mem_transaction_tag_i,
  input  logic       mem_transaction_handshake_i,
  input  MEM_TAG     mem_data_tag_i,
  input  MEM_BLOCK   mem_data_i
);

  MEM_ARB_STATE        state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                hs_valid, if_accept, dc_accept, if_starved;
  logic                alloc_en, ret_squashed;
  MEM_OWNER            ret_owner;

  assign hs_valid  = mem_transaction_handshake_i && (mem_transaction_tag_i != '0);
  assign if_accept = hs_valid && (state_q == ARB_GNT_IF) && if_req_i;
  assign dc_accept = hs_valid && (state_q == ARB_GNT_DC) && dc_req_i;

  // Starvation uses the post-update count so the limit-th dcache accept hands over at once
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_accept) starve_cnt_d = '0;
    else if (dc_accept && starve_cnt_q != STARVE_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  assign if_starved = if_req_i && (starve_cnt_d == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   state_d = arb_pick(if_req_i, dc_req_i, if_starved);
      ARB_GNT_IF: begin
        if (if_accept) state_d = arb_pick(if_req_i, dc_req_i, if_starved);
        else if (!if_req_i) state_d = ARB_IDLE;
      end
      ARB_GNT_DC: begin
        if (dc_accept) state_d = arb_pick(if_req_i, dc_req_i, if_starved);
        else if (!dc_req_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    mem_command_o = MEM_NONE;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    if (state_q == ARB_GNT_IF && if_req_i) begin
      mem_command_o = MEM_LOAD;
      mem_addr_o    = if_addr_i;
    end else if (state_q == ARB_GNT_DC && dc_req_i) begin
      mem_command_o = dc_cmd_i;
      mem_addr_o    = dc_addr_i;
      mem_wdata_o   = dc_wdata_i;
    end
  end

  assign if_ack_o = if_accept;
  assign dc_ack_o = dc_accept;
  assign if_tag_o = if_accept ? mem_transaction_tag_i : '0;
  assign dc_tag_o = dc_accept ? mem_transaction_tag_i : '0;
  assign alloc_en = if_accept || (dc_accept && dc_cmd_i == MEM_LOAD);

  mem_tag_table u_tag_table (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_en_i     (alloc_en),
    .alloc_tag_i    (mem_transaction_tag_i),
    .alloc_owner_i  (if_accept ? OWN_IF : OWN_DC),
    .squash_if_i    (if_squash_i),
    .ret_tag_i      (mem_data_tag_i),
    .ret_owner_o    (ret_owner),
    .ret_squashed_o (ret_squashed)
  );

  always_comb begin
    if_data_tag_o = '0;
    if_data_o     = '0;
    dc_data_tag_o = '0;
    dc_data_o     = '0;
    if (mem_data_tag_i != '0) begin
      if (ret_owner == OWN_IF && !ret_squashed) begin
        if_data_tag_o = mem_data_tag_i;
        if_data_o     = mem_data_i;
      end else if (ret_owner == OWN_DC) begin
        dc_data_tag_o = mem_data_tag_i;
        dc_data_o     = mem_data_i;
      end
    end
  end

endmodule
